// File: rtl/mult_controller.sv
// Sequencing FSM for the shift-add multiplier: drives load / add_shift / shift
// of the C/AQ register and flags done. Optional abort input: MULT_CTRL_ABORT_EN.
module mult_controller #(
  parameter int N = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic q0,
`ifdef MULT_CTRL_ABORT_EN
  input  logic abort,
`endif
  output logic load,
  output logic add_shift,
  output logic shift,
  output logic ready,
  output logic done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          load_q, load_d;
  logic          run_q, run_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          abort_hit;

  always_comb begin
`ifdef MULT_CTRL_ABORT_EN
    abort_hit = abort;
`else
    abort_hit = 1'b0;
`endif
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        count_d = '0;
        state_d = abort_hit ? IDLE : RUN;
      end
      RUN: begin
        if (abort_hit) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
          if (count_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    // Outputs are registered by decoding the state we are about to enter.
    load_d  = (state_d == LOAD);
    run_d   = (state_d == RUN);
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      load_q  <= 1'b0;
      run_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      load_q  <= load_d;
      run_q   <= run_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // q0 comes straight back from the register, so the step choice stays combinational.
  assign load      = load_q;
  assign add_shift = run_q & q0;
  assign shift     = run_q & ~q0;
  assign ready     = ready_q;
  assign done      = done_q;

endmodule
